// File: rtl/sprite_move_ctl_if.sv
// ---------------------------------------------------------------------------
// sprite_move_ctl_if
//  Groups the frame/button inputs and the sprite position outputs of the
//  sprite movement controller. The master side (timing chain + button
//  synchronisers, or a testbench) drives vsync and buttons; the slave side
//  (the controller) drives the sprite position, floor flag and frame tick.
// ---------------------------------------------------------------------------
interface sprite_move_ctl_if;
   logic        vsync;
   logic        btn_left;
   logic        btn_right;
   logic        btn_jump;
   logic [11:0] x_start;
   logic [11:0] y_start;
   logic        on_floor;
   logic        frame_tick;

   modport master (
      output vsync, btn_left, btn_right, btn_jump,
      input  x_start, y_start, on_floor, frame_tick
   );

   modport slave (
      input  vsync, btn_left, btn_right, btn_jump,
      output x_start, y_start, on_floor, frame_tick
   );
endinterface

// File: rtl/sprite_move_ctl.sv
// ---------------------------------------------------------------------------
// sprite_move_ctl
//  Per-frame position controller for the sprite rectangle. Walks left/right
//  while buttons are held, jumps along a gravity arc and lands on the floor
//  line. Position and state change only once per frame (on the internal frame
//  tick that follows a vsync rising edge), so the drawing stage never sees a
//  mid-frame move.
//
//  Optional feature macro: DOUBLE_JUMP_EN
//   defined   -> one extra jump is allowed per airborne phase
//   undefined -> airborne jump requests are dropped
//
//  Timing: vsync rising edge is registered into frame_tick (one cycle pulse);
//  during that cycle the new position/state is computed and it appears on
//  x_start/y_start/on_floor at the following clock edge.
// ---------------------------------------------------------------------------
module sprite_move_ctl #(
   parameter int SCREEN_W = 1024,
   parameter int SCREEN_H = 768,
   parameter int SPRITE_W = 48,
   parameter int SPRITE_H = 64,
   parameter int START_X  = 488,
   parameter int X_STEP   = 4,
   parameter int JUMP_V0  = 16,
   parameter int GRAVITY  = 1,
   parameter int MAX_FALL = 24
) (
   input  logic              clk65MHz,
   input  logic              rst,
   sprite_move_ctl_if.slave  bus
);

   // 13-bit signed copies of the geometry so that over/underflow is visible
   localparam logic signed [12:0] X_MAX_S   = 13'(SCREEN_W - SPRITE_W);
   localparam logic signed [12:0] FLOOR_S   = 13'(SCREEN_H - SPRITE_H);
   localparam logic signed [12:0] X_STEP_S  = 13'(X_STEP);
   localparam logic signed [12:0] JUMP_V0_S = 13'(JUMP_V0);
   localparam logic        [11:0] START_X_U = 12'(START_X);
   localparam logic        [11:0] FLOOR_U   = 12'(SCREEN_H - SPRITE_H);
   localparam logic        [11:0] X_MAX_U   = 12'(SCREEN_W - SPRITE_W);
   localparam logic        [7:0]  JUMP_V0_U = 8'(JUMP_V0);
   localparam logic        [7:0]  GRAVITY_U = 8'(GRAVITY);
   localparam logic        [7:0]  MAX_FALL_U = 8'(MAX_FALL);
   // velocity left over after the launch frame of a ground jump
   localparam logic        [7:0]  LAUNCH_V_U = 8'(JUMP_V0 - GRAVITY);

   typedef enum logic [1:0] {
      ST_GROUND = 2'd0,
      ST_RISE   = 2'd1,
      ST_FALL   = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // State registers and their next-state values
   // ------------------------------------------------------------------
   logic        vsync_q;
   logic        btn_jump_q;
   logic        tick_q;
   logic        jump_req_q,  jump_req_d;
   logic [11:0] x_q,         x_d;
   logic [11:0] y_q,         y_d;
   logic [7:0]  vel_q,       vel_d;
   state_t      state_q,     state_d;
   logic        on_floor_q;

   // ------------------------------------------------------------------
   // Edge detection and arithmetic helpers
   // ------------------------------------------------------------------
   logic               tick_s;
   logic               jump_edge_s;
   logic               jump_now_s;
   logic               dj_take_s;
   logic signed [12:0] x_ext_s;
   logic signed [12:0] x_sum_s;
   logic signed [12:0] y_ext_s;
   logic signed [12:0] vel_ext_s;
   logic signed [12:0] y_jump_s;
   logic signed [12:0] y_rise_s;
   logic        [8:0]  vel_inc_s;
   logic        [7:0]  vel_fall_s;
   logic signed [12:0] y_fall_s;

   assign tick_s      = bus.vsync & ~vsync_q;
   assign jump_edge_s = bus.btn_jump & ~btn_jump_q;
   // an edge landing on the tick cycle itself is serviced by that tick
   assign jump_now_s  = jump_req_q | jump_edge_s;

   assign x_ext_s   = $signed({1'b0, x_q});
   assign y_ext_s   = $signed({1'b0, y_q});
   assign vel_ext_s = $signed({5'b00000, vel_q});
   assign y_jump_s  = y_ext_s - JUMP_V0_S;
   assign y_rise_s  = y_ext_s - vel_ext_s;
   assign vel_inc_s = {1'b0, vel_q} + {1'b0, GRAVITY_U};
   assign vel_fall_s = (vel_inc_s > {1'b0, MAX_FALL_U}) ? MAX_FALL_U : vel_inc_s[7:0];
   assign y_fall_s  = y_ext_s + $signed({5'b00000, vel_fall_s});

`ifdef DOUBLE_JUMP_EN
   logic dj_used_q, dj_used_d;
   assign dj_take_s = jump_now_s & ~dj_used_q & (state_q != ST_GROUND);
`else
   assign dj_take_s = 1'b0;
`endif

   // Jump request latch: set by a button edge, dropped on every frame tick
   always_comb begin
      jump_req_d = jump_req_q;
      if (tick_q) begin
         jump_req_d = 1'b0;
      end else if (jump_edge_s) begin
         jump_req_d = 1'b1;
      end else begin
         jump_req_d = jump_req_q;
      end
   end

   // Horizontal move with clamping to the visible range
   always_comb begin
      x_sum_s = x_ext_s;
      x_d     = x_q;
      if (tick_q) begin
         if (bus.btn_left && !bus.btn_right) begin
            x_sum_s = x_ext_s - X_STEP_S;
         end else if (bus.btn_right && !bus.btn_left) begin
            x_sum_s = x_ext_s + X_STEP_S;
         end else begin
            x_sum_s = x_ext_s;
         end
         if (x_sum_s < 13'sd0) begin
            x_d = 12'd0;
         end else if (x_sum_s > X_MAX_S) begin
            x_d = X_MAX_U;
         end else begin
            x_d = x_sum_s[11:0];
         end
      end else begin
         x_d = x_q;
      end
   end

   // Vertical FSM: ground / rising / falling with gravity and landing
   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      vel_d   = vel_q;
      if (tick_q) begin
         case (state_q)
            ST_GROUND: begin
               if (jump_now_s) begin
                  if (y_jump_s < 13'sd0) begin
                     y_d     = 12'd0;
                     vel_d   = 8'd0;
                     state_d = ST_FALL;
                  end else begin
                     y_d     = y_jump_s[11:0];
                     vel_d   = LAUNCH_V_U;
                     state_d = ST_RISE;
                  end
               end else begin
                  state_d = ST_GROUND;
               end
            end
            ST_RISE: begin
               if (dj_take_s) begin
                  if (y_jump_s < 13'sd0) begin
                     y_d     = 12'd0;
                     vel_d   = 8'd0;
                     state_d = ST_FALL;
                  end else begin
                     y_d     = y_jump_s[11:0];
                     vel_d   = JUMP_V0_U;
                     state_d = ST_RISE;
                  end
               end else if (y_rise_s < 13'sd0) begin
                  // ceiling hit: pin to the top and start falling
                  y_d     = 12'd0;
                  vel_d   = 8'd0;
                  state_d = ST_FALL;
               end else begin
                  y_d = y_rise_s[11:0];
                  if (vel_q <= GRAVITY_U) begin
                     vel_d   = 8'd0;
                     state_d = ST_FALL;
                  end else begin
                     vel_d   = vel_q - GRAVITY_U;
                     state_d = ST_RISE;
                  end
               end
            end
            ST_FALL: begin
               if (dj_take_s) begin
                  if (y_jump_s < 13'sd0) begin
                     y_d     = 12'd0;
                     vel_d   = 8'd0;
                     state_d = ST_FALL;
                  end else begin
                     y_d     = y_jump_s[11:0];
                     vel_d   = JUMP_V0_U;
                     state_d = ST_RISE;
                  end
               end else if (y_fall_s >= FLOOR_S) begin
                  // landing takes effect on the same tick
                  y_d     = FLOOR_U;
                  vel_d   = 8'd0;
                  state_d = ST_GROUND;
               end else begin
                  y_d     = y_fall_s[11:0];
                  vel_d   = vel_fall_s;
                  state_d = ST_FALL;
               end
            end
            default: begin
               // illegal encoding: fall from wherever we are and re-land
               vel_d   = 8'd0;
               state_d = ST_FALL;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Edge registers, frame tick and all position/state registers
   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         vsync_q    <= 1'b0;
         btn_jump_q <= 1'b0;
         tick_q     <= 1'b0;
         jump_req_q <= 1'b0;
         x_q        <= START_X_U;
         y_q        <= FLOOR_U;
         vel_q      <= 8'd0;
         state_q    <= ST_GROUND;
         on_floor_q <= 1'b1;
      end else begin
         vsync_q    <= bus.vsync;
         btn_jump_q <= bus.btn_jump;
         tick_q     <= tick_s;
         jump_req_q <= jump_req_d;
         x_q        <= x_d;
         y_q        <= y_d;
         vel_q      <= vel_d;
         state_q    <= state_d;
         on_floor_q <= (state_d == ST_GROUND);
      end
   end

`ifdef DOUBLE_JUMP_EN
   // Double-jump credit: spent on an airborne jump, refilled on landing
   always_comb begin
      dj_used_d = dj_used_q;
      if (tick_q) begin
         if (dj_take_s) begin
            dj_used_d = 1'b1;
         end else if (state_d == ST_GROUND) begin
            dj_used_d = 1'b0;
         end else begin
            dj_used_d = dj_used_q;
         end
      end else begin
         dj_used_d = dj_used_q;
      end
   end

   // Double-jump credit register
   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         dj_used_q <= 1'b0;
      end else begin
         dj_used_q <= dj_used_d;
      end
   end
`endif

   assign bus.x_start    = x_q;
   assign bus.y_start    = y_q;
   assign bus.on_floor   = on_floor_q;
   assign bus.frame_tick = tick_q;

endmodule
